// File: rtl/fetch_control_unit_if.sv
// Instruction-memory read bus between the fetch control unit (master) and the instruction memory (slave).
interface fetch_control_unit_if #(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int INSTR_WIDTH      = 32
);
  logic                        imem_req;
  logic [INSTR_ADDR_WIDTH-1:0] imem_addr;
  logic                        imem_ack;
  logic [INSTR_WIDTH-1:0]      imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_control_unit.sv
// Fetch sequencer: FETCH -> ISSUE -> ADVANCE per instruction, HALT at end of program memory.
// Optional build macro FETCH_TIMEOUT_EN adds a FETCH watchdog that raises a sticky fault.
module fetch_control_unit #(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int INSTR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc,
  input  logic                        pc_end,
  output logic                        pc_en,
  output logic                        pc_src,
  fetch_control_unit_if.master        imem,
  output logic [INSTR_WIDTH-1:0]      instr,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  input  logic                        branch_taken,
  output logic [31:0]                 retired,
  output logic                        busy,
  output logic                        halted,
  output logic                        fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_ADVANCE = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [INSTR_WIDTH-1:0]   instr_q;
  logic                     pc_src_q;
  logic [31:0]              retired_q;
  logic                     fetch_ack;
  logic                     handshake;
  logic                     timeout_hit;

  assign fetch_ack = (state_q == S_FETCH) && imem.imem_ack;
  assign handshake = (state_q == S_ISSUE) && instr_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;
  logic          fault_q;

  // Counter holds the number of ack-less FETCH cycles so far; it sits at zero outside FETCH.
  assign timeout_hit = (state_q == S_FETCH) && !imem.imem_ack && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q != S_FETCH)    tmo_q <= '0;
      else if (!imem.imem_ack)   tmo_q <= tmo_q + 1'b1;
      if (timeout_hit)           fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: each always_comb assigns a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ack)    state_d = S_ISSUE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_ISSUE: begin
        if (instr_ready) state_d = (pc_end && !branch_taken) ? S_HALT : S_ADVANCE;
      end
      S_ADVANCE: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en         = 1'b0;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    busy          = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      S_FETCH:   begin imem.imem_req = 1'b1; busy = 1'b1; end
      S_ISSUE:   begin instr_valid   = 1'b1; busy = 1'b1; end
      S_ADVANCE: begin pc_en         = 1'b1; busy = 1'b1; end
      S_HALT:    halted = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      pc_src_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (fetch_ack)             instr_q   <= imem.imem_rdata;
      if (handshake)             pc_src_q  <= branch_taken;
      if (state_q == S_ADVANCE)  retired_q <= retired_q + 32'd1;
    end
  end

  assign imem.imem_addr = pc;
  assign instr          = instr_q;
  assign pc_src         = pc_src_q;
  assign retired        = retired_q;

endmodule

// File: doc/fetch_control_unit.md
FETCH_CONTROL_UNIT -- requirements
Module: fetch_control_unit

Interface
REQ-001 Parameter INSTR_ADDR_WIDTH, default 20, PC and instruction-memory address width in bits.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction word width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, FETCH cycles without imem_ack before fault; only used with FETCH_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin fetching from the current pc; honoured only in IDLE.
REQ-007 pc  in  INSTR_ADDR_WIDTH  current program counter from the PC unit.
REQ-008 pc_end  in  1  high when pc is all-ones.
REQ-009 pc_en  out  1  one-cycle enable pulse to the PC unit.
REQ-010 pc_src  out  1  PC unit select: 0 = pc_plus, 1 = pc_branch; meaningful only while pc_en=1.
REQ-011 imem_req  out  1  instruction-memory read request.
REQ-012 imem_addr  out  INSTR_ADDR_WIDTH  read address; equals pc.
REQ-013 imem_ack  in  1  read-data-valid acknowledge.
REQ-014 imem_rdata  in  INSTR_WIDTH  read data; valid when imem_ack=1.
REQ-015 instr  out  INSTR_WIDTH  registered instruction to decode.
REQ-016 instr_valid  out  1  instr holds an unconsumed instruction.
REQ-017 instr_ready  in  1  decode/execute consumes instr.
REQ-018 branch_taken  in  1  branch/jump taken for the instruction being consumed.
REQ-019 retired  out  32  count of advanced instructions.
REQ-020 busy  out  1  high in FETCH, ISSUE or ADVANCE.
REQ-021 halted  out  1  high in HALT.
REQ-022 fault  out  1  sticky fetch-timeout flag.

Function
REQ-023 FSM states: IDLE, FETCH, ISSUE, ADVANCE, HALT; one state per cycle, registered.
REQ-024 IDLE: start=1 -> FETCH next cycle; start=0 -> stay in IDLE.
REQ-025 FETCH: imem_req=1, imem_addr=pc; imem_ack=1 (including the first FETCH cycle) -> capture imem_rdata into instr, go to ISSUE; imem_req is 0 from the next cycle.
REQ-026 ISSUE: instr_valid=1 with instr stable; instr_ready=1 -> latch branch_taken into pc_src.
REQ-027 ISSUE handshake with pc_end=1 and branch_taken=0 -> HALT, no pc_en pulse, retired not incremented; otherwise -> ADVANCE.
REQ-028 ADVANCE: pc_en=1 for exactly one cycle with the latched pc_src; retired += 1, wrapping modulo 2^32; next state FETCH.
REQ-029 pc_en, imem_req and instr_valid are never high outside ADVANCE, FETCH and ISSUE respectively.
REQ-030 Minimum throughput: 3 cycles per instruction (FETCH, ISSUE, ADVANCE) with same-cycle ack and ready.
REQ-031 instr_ready outside ISSUE, imem_ack outside FETCH, and branch_taken outside the ISSUE handshake are ignored.
REQ-032 start outside IDLE is ignored; HALT is left only by rst.
REQ-033 pc_src holds its last latched value between ADVANCE pulses.

Reset
REQ-034 rst=1 at a rising edge forces IDLE from any state, including mid-FETCH with an outstanding request, on the next cycle.
REQ-035 Reset values: pc_en=0, pc_src=0, imem_req=0, instr=0, instr_valid=0, retired=0, busy=0, halted=0, fault=0, timeout counter=0.

Configuration
REQ-036 Macro FETCH_TIMEOUT_EN defined: a counter clears on FETCH entry and increments each FETCH cycle without imem_ack; reaching TIMEOUT_CYCLES sets fault=1 (sticky until rst) and moves to HALT; an ack in the same cycle takes precedence.
REQ-037 Macro FETCH_TIMEOUT_EN undefined: no counter is built, fault is tied to 0, and FETCH waits indefinitely for imem_ack.

Verification
REQ-038 Reset, then start=1 with pc=0x00010, ack and ready same-cycle, branch_taken=0 -> imem_addr=0x00010 in cycle 1, instr_valid in cycle 2, pc_en=1 with pc_src=0 in cycle 3, retired=1.
REQ-039 ISSUE with branch_taken=1 at handshake -> single pc_en pulse with pc_src=1; next FETCH uses pc supplied by the PC unit.
REQ-040 imem_ack delayed 4 cycles, instr_ready delayed 2 cycles -> imem_req high for exactly 5 cycles, instr stable and instr_valid high for exactly 3 cycles, one pc_en pulse.
REQ-041 pc=0xFFFFF, pc_end=1, branch_taken=0 at handshake -> HALT, halted=1, no pc_en pulse, retired unchanged; start ignored afterwards.
REQ-042 rst asserted during FETCH with imem_req=1 -> IDLE next cycle with all outputs at reset values.
REQ-043 With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no ack -> fault=1 and halted=1 after 8 FETCH cycles; without the macro, imem_req stays high and fault=0.
